// File: rtl/wreq_queue_mngr.sv
// Write-request queue and AW issuer: buffers line writes, issues one
// 4-beat INCR burst at a time, hands head entry to the W data manager.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   push handshake (ready = ~full)
//   req_addr/id/wdata/mask  request payload
//   aw*                   AXI AW channel (len=3, size=2, INCR)
//   next_rq               1-cycle burst start pulse
//   next_id/wdata/mask    head entry, held until finish_wd
//   finish_wd/finish_id   last W beat accepted, its id
//   id_err                sticky id mismatch flag
//
// Build option: define ID_CHK_EN to compare finish_id with the head id
// on retire and raise id_err on mismatch. Undefined: id_err tied 0.

module wreq_queue_mngr #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_id,
  input  logic [127:0]  req_wdata,
  input  logic [15:0]   req_mask,
  output logic          awvalid,
  input  logic          awready,
  output logic [AW-1:0] awaddr,
  output logic [3:0]    awid,
  output logic [7:0]    awlen,
  output logic [2:0]    awsize,
  output logic [1:0]    awburst,
  output logic          next_rq,
  output logic [3:0]    next_id,
  output logic [127:0]  next_wdata,
  output logic [15:0]   next_mask,
  input  logic          finish_wd,
  input  logic [3:0]    finish_id,
  output logic          id_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    AWOUT,
    DSTART,
    DWAIT
  } state_e;

  state_e state_q, state_d;

  logic [AW-5:0] addr_q [DEPTH];
  logic [3:0]    id_q   [DEPTH];
  logic [127:0]  data_q [DEPTH];
  logic [15:0]   mask_q [DEPTH];

  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];

  // Extra wrap bit distinguishes full from empty.
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW])
              && (wr_idx == rd_idx);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready comes from full alone so that a retire in the
  // same cycle never creates a combinational path.
  assign req_ready = ~full;
  assign push      = req_valid & ~full;

  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        id_q[i]   <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_idx] <= req_addr[AW-1:4];
      id_q[wr_idx]   <= req_id;
      data_q[wr_idx] <= req_wdata;
      mask_q[wr_idx] <= req_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    awvalid = 1'b0;
    next_rq = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = AWOUT;
        end
      end
      AWOUT: begin
        awvalid = 1'b1;
        if (awready) begin
          state_d = DSTART;
        end
      end
      DSTART: begin
        next_rq = 1'b1;
        state_d = DWAIT;
      end
      DWAIT: begin
        if (finish_wd) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Head entry drives both channels directly; it only
  // moves on retire, so it is stable across AW and W.
  assign awaddr  = {addr_q[rd_idx], 4'h0};
  assign awid    = id_q[rd_idx];
  assign awlen   = 8'd3;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;

  assign next_id    = id_q[rd_idx];
  assign next_wdata = data_q[rd_idx];
  assign next_mask  = mask_q[rd_idx];

`ifdef ID_CHK_EN
  logic err_q, err_d;

  assign err_d = err_q
              | (pop & (finish_id != id_q[rd_idx]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign id_err = err_q;

  logic unused_bits;
  assign unused_bits = ^req_addr[3:0];
`else
  assign id_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{req_addr[3:0], finish_id};
`endif

endmodule

// File: tb/tb_wreq_queue_mngr.sv
// Directed bench for wreq_queue_mngr: issue order, full/empty
// boundaries, ignored finish pulses, id check, async reset.

module tb_wreq_queue_mngr;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [3:0]   req_id;
  logic [127:0] req_wdata;
  logic [15:0]  req_mask;
  logic         awvalid;
  logic         awready;
  logic [31:0]  awaddr;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         next_rq;
  logic [3:0]   next_id;
  logic [127:0] next_wdata;
  logic [15:0]  next_mask;
  logic         finish_wd;
  logic [3:0]   finish_id;
  logic         id_err;

  int checks = 0;
  int fails  = 0;

`ifdef ID_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam logic [127:0] W1 =
    128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] W2 =
    128'h1111_2222_3333_4444_5555_6666_7777_8888;

  wreq_queue_mngr #(.DEPTH(4), .AW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_id     (req_id),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awid       (awid),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .next_rq    (next_rq),
    .next_id    (next_id),
    .next_wdata (next_wdata),
    .next_mask  (next_mask),
    .finish_wd  (finish_wd),
    .finish_id  (finish_id),
    .id_err     (id_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a,
                      input logic [3:0] id,
                      input logic [127:0] d,
                      input logic [15:0] m);
    req_valid = 1'b1;
    req_addr  = a;
    req_id    = id;
    req_wdata = d;
    req_mask  = m;
    tick();
    req_valid = 1'b0;
  endtask

  // Starts in an AWOUT cycle with awready=1, ends in IDLE.
  task automatic issue(input logic [3:0] id,
                       input logic [3:0] fid);
    chk("iss_awvalid", awvalid, 1'b1);
    chk("iss_awid", awid, id);
    tick();
    chk("iss_next_rq", next_rq, 1'b1);
    chk("iss_next_id", next_id, id);
    tick();
    chk("iss_rq_low", next_rq, 1'b0);
    finish_wd = 1'b1;
    finish_id = fid;
    tick();
    finish_wd = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_id    = '0;
    req_wdata = '0;
    req_mask  = '0;
    awready   = 1'b0;
    finish_wd = 1'b0;
    finish_id = '0;
    repeat (3) tick();
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_next_rq", next_rq, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_id_err", id_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // single request, full round trip
    awready = 1'b1;
    push(32'h1000_0014, 4'd3, W1, 16'hA5F0);
    chk("t1_aw_early", awvalid, 1'b0);
    tick();
    chk("t1_awvalid", awvalid, 1'b1);
    chk("t1_awaddr", awaddr, 32'h1000_0010);
    chk("t1_awid", awid, 4'd3);
    chk("t1_awlen", awlen, 8'd3);
    chk("t1_awsize", awsize, 3'd2);
    chk("t1_awburst", awburst, 2'b01);
    tick();
    chk("t1_next_rq", next_rq, 1'b1);
    chk("t1_aw_drop", awvalid, 1'b0);
    chk("t1_next_id", next_id, 4'd3);
    chk("t1_wdata", next_wdata, W1);
    chk("t1_mask", next_mask, 16'hA5F0);
    tick();
    chk("t1_rq_pulse", next_rq, 1'b0);
    chk("t1_wdata_hold", next_wdata, W1);
    finish_wd = 1'b1;
    finish_id = 4'd3;
    tick();
    finish_wd = 1'b0;
    chk("t1_ready", req_ready, 1'b1);
    tick();
    chk("t1_empty_idle", awvalid, 1'b0);

    // finish_wd in IDLE and AWOUT is ignored
    awready = 1'b0;
    push(32'h2000_0000, 4'd7, W2, 16'hFFFF);
    finish_wd = 1'b1;
    finish_id = 4'd7;
    tick();
    chk("t4_awvalid", awvalid, 1'b1);
    chk("t4_awid", awid, 4'd7);
    tick();
    finish_wd = 1'b0;
    chk("t4_hold_valid", awvalid, 1'b1);
    chk("t4_hold_id", awid, 4'd7);

    // fill to DEPTH while AW stalled
    push(32'h2000_0100, 4'd8, W1, 16'h000F);
    chk("t2_ready2", req_ready, 1'b1);
    push(32'h2000_0200, 4'd9, W1, 16'h00F0);
    chk("t2_ready3", req_ready, 1'b1);
    push(32'h2000_0300, 4'd10, W1, 16'h0F00);
    chk("t2_full", req_ready, 1'b0);
    chk("t2_aw_held", awvalid, 1'b1);
    chk("t2_awid_held", awid, 4'd7);
    chk("t2_awaddr_held", awaddr, 32'h2000_0000);
    push(32'h2000_0400, 4'd11, W2, 16'hF000);
    chk("t2_still_full", req_ready, 1'b0);
    chk("t2_awid_still", awid, 4'd7);

    // retire and push in the same cycle while full
    awready = 1'b1;
    tick();
    chk("t3_next_rq", next_rq, 1'b1);
    chk("t3_next_id", next_id, 4'd7);
    chk("t3_wdata", next_wdata, W2);
    tick();
    finish_wd = 1'b1;
    finish_id = 4'd7;
    req_valid = 1'b1;
    req_addr  = 32'h2000_0400;
    req_id    = 4'd11;
    req_wdata = W2;
    req_mask  = 16'hF000;
    chk("t3_ready_full", req_ready, 1'b0);
    tick();
    finish_wd = 1'b0;
    chk("t3_ready_after", req_ready, 1'b1);
    chk("t3_head", next_id, 4'd8);
    tick();
    req_valid = 1'b0;
    chk("t3_full_again", req_ready, 1'b0);

    // drain in FIFO order
    issue(4'd8, 4'd8);
    tick();
    issue(4'd9, 4'd9);
    tick();
    issue(4'd10, 4'd10);
    tick();
    chk("t2_mask11", next_mask, 16'hF000);
    issue(4'd11, 4'd11);
    chk("t2_drained", req_ready, 1'b1);
    chk("t2_no_err", id_err, 1'b0);
    tick();
    chk("t2_idle", awvalid, 1'b0);

    // id mismatch on retire
    push(32'h3000_0040, 4'd2, W2, 16'h1234);
    tick();
    issue(4'd2, 4'd5);
    chk("t6_id_err", id_err, ERR_EXP);
    chk("t6_popped", awvalid, 1'b0);
    tick();
    tick();
    chk("t6_sticky", id_err, ERR_EXP);
    chk("t6_ready", req_ready, 1'b1);

    // async reset during DWAIT with full queue
    push(32'h4000_0000, 4'd4, W1, 16'h1111);
    push(32'h4000_0010, 4'd5, W1, 16'h2222);
    push(32'h4000_0020, 4'd6, W1, 16'h3333);
    push(32'h4000_0030, 4'd12, W1, 16'h4444);
    chk("t5_pre_full", req_ready, 1'b0);
    chk("t5_pre_id", next_id, 4'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_awvalid", awvalid, 1'b0);
    chk("t5_next_rq", next_rq, 1'b0);
    chk("t5_ready", req_ready, 1'b1);
    chk("t5_id_err", id_err, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_empty", awvalid, 1'b0);
    chk("t5_ready2", req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
